// File: rtl/wb_regfile.sv
// wb_regfile
//   General-purpose register file of the 5-stage pipelined CPU. It is the
//   consuming end of the write-back path: the MEM/WB register presents a
//   (register, enable, data) triple that is committed on the rising edge.
//   Two decode-stage read ports see a write-back happening in the same cycle
//   through a bypass. A registered debug port serves board-level display.
//
// Ports
//   clk            system clock, all state updates on the rising edge
//   rst            synchronous, active-high reset
//   wb_we          write-back enable
//   wb_write_reg   write-back destination register
//   wb_write_data  write-back data
//   re1/raddr1     read enable / address, port 1 (rs)
//   rdata1         read data, port 1 (combinational, bypassed)
//   re2/raddr2     read enable / address, port 2 (rt)
//   rdata2         read data, port 2 (combinational, bypassed)
//   dbg_addr       debug read address
//   dbg_data       debug read data (one-cycle latency, no bypass)
//   wb_count       committed architectural writes since reset (wraps)
module wb_regfile #(
  parameter int                 DATA_W   = 32,
  parameter int                 ADDR_W   = 5,
  parameter logic [DATA_W-1:0]  SP_RESET = 32'h0000_7FFC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_write_reg,
  input  logic [DATA_W-1:0] wb_write_data,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [15:0]       wb_count
);

  localparam int NREG   = 1 << ADDR_W;
  localparam int SP_IDX = 29;

  logic [DATA_W-1:0] r_regs [NREG];
  logic [DATA_W-1:0] r_dbgData;
  logic [15:0]       r_wbCount;
  logic              w_commit;

  // Writes to register 0 are not architectural: they neither land nor count.
  assign w_commit = wb_we && (wb_write_reg != '0);

  // Storage, debug register and commit counter. Entry 0 is never written and
  // resets to zero, so it stays hardwired to zero. The debug port reads the
  // storage before this edge's write lands, so it returns the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
      end
      r_dbgData <= '0;
      r_wbCount <= '0;
    end else begin
      if (w_commit) begin
        r_regs[wb_write_reg] <= wb_write_data;
        r_wbCount            <= r_wbCount + 16'd1;
      end
      r_dbgData <= (dbg_addr == '0) ? '0 : r_regs[dbg_addr];
    end
  end

  // Read-port selection in priority order: reset, disabled, register 0,
  // same-cycle write-back bypass, then storage.
  function automatic logic [DATA_W-1:0] readPort(
    input logic              iRst,
    input logic              iRe,
    input logic [ADDR_W-1:0] iAddr,
    input logic              iWe,
    input logic [ADDR_W-1:0] iWbReg,
    input logic [DATA_W-1:0] iWbData,
    input logic [DATA_W-1:0] iStored
  );
    logic [DATA_W-1:0] result;
    result = iStored;
    if (iRst || !iRe || (iAddr == '0)) begin
      result = '0;
    end else if (iWe && (iWbReg == iAddr)) begin
      result = iWbData;
    end
    return result;
  endfunction

  always_comb begin
    rdata1 = '0;
    rdata1 = readPort(rst, re1, raddr1, wb_we, wb_write_reg, wb_write_data,
                      r_regs[raddr1]);
  end

  always_comb begin
    rdata2 = '0;
    rdata2 = readPort(rst, re2, raddr2, wb_we, wb_write_reg, wb_write_data,
                      r_regs[raddr2]);
  end

  assign dbg_data = r_dbgData;
  assign wb_count = r_wbCount;

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- 32 x 32-bit general-purpose register file of the 5-stage pipelined CPU; this is the consuming end of the write-back path.
- Accepts the write-back triple (register address, write enable, write data) registered out of the MEM/WB pipeline register.
- Serves two decode-stage (ID) operand read ports in the same cycle.
- Provides WB-to-ID bypass so an instruction in ID sees a value being written back in that cycle, plus one debug read port for board-level display.

Parameters:
- DATA_W, 32, register and data width.
- ADDR_W, 5, register address width (32 entries).
- SP_RESET, 32'h0000_7FFC, value loaded into register 29 ($sp) on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- wb_we  input  1  write-back enable from MEM/WB.
- wb_write_reg  input  ADDR_W  write-back destination register.
- wb_write_data  input  DATA_W  write-back data.
- re1  input  1  read enable, port 1 (rs).
- raddr1  input  ADDR_W  read address, port 1.
- rdata1  output  DATA_W  read data, port 1 (combinational).
- re2  input  1  read enable, port 2 (rt).
- raddr2  input  ADDR_W  read address, port 2.
- rdata2  output  DATA_W  read data, port 2 (combinational).
- dbg_addr  input  ADDR_W  debug read address.
- dbg_data  output  DATA_W  debug read data (registered).
- wb_count  output  16  number of committed architectural writes since reset.

Behaviour:
- Reset (rst=1 at rising clk):
  - All entries cleared to 0, except entry 29, which loads SP_RESET.
  - dbg_data <= 0; wb_count <= 0.
  - Any write presented in the same cycle is discarded.
- Combinational outputs while rst=1: rdata1 = rdata2 = 0 regardless of other inputs.
- Write:
  - On rising clk with rst=0, wb_we=1 and wb_write_reg!=0: entry[wb_write_reg] <= wb_write_data, and wb_count increments by 1.
  - wb_count wraps 16'hFFFF -> 0.
- Register 0:
  - Hardwired to 0; writes to it are ignored and do not increment wb_count.
  - Reads of address 0 always return 0, including under bypass.
- Read port n (n = 1, 2), combinational, in priority order:
  - rst=1 -> 0.
  - re_n=0 -> 0.
  - raddr_n=0 -> 0.
  - wb_we=1 and wb_write_reg==raddr_n -> wb_write_data (bypass, same cycle).
  - Otherwise -> entry[raddr_n].
- Both ports may address the same register, and may both hit the bypass at once; each returns the identical value.
- Read-after-write latency:
  - 0 cycles via bypass.
  - The value appears in storage from the next cycle onward.
- Debug port:
  - dbg_data <= entry[dbg_addr] on each rising clk (1-cycle latency).
  - Returns the pre-write value if the same register is written in that cycle (no bypass).
  - Address 0 returns 0.
- Reset mid-operation: a write coinciding with reset is lost; the first post-reset edge with wb_we=1 commits normally.
- No stall input: the MEM/WB register already holds during stall, and repeated identical writes are idempotent.
- wb_count counts each such repeated write.

Test Plan:
- Reset: pulse rst 1 cycle, then read all 32 registers on port 1 -> reg29 = 32'h0000_7FFC, all others 0, wb_count = 0.
- Write then read: wb_we=1, reg 5 <= 32'hDEADBEEF at edge; next cycle, re1=1 raddr1=5 -> rdata1 = 32'hDEADBEEF; wb_count = 1.
- Same-cycle bypass: reg 7 holds 32'h11; present wb_we=1, reg 7, 32'h22; re1=re2=1, raddr1=raddr2=7 -> both ports 32'h22 before the edge; after the edge storage = 32'h22.
- Zero register: wb_we=1, reg 0 <= 32'hFFFFFFFF; read port 2 addr 0 in same and next cycle -> 0; wb_count unchanged.
- Read disable and debug: re1=0 with raddr1=5 -> rdata1 = 0; dbg_addr=5 -> dbg_data = 32'hDEADBEEF one edge later; write reg 5 <= 32'h1 with dbg_addr=5 -> dbg_data = old value, then 32'h1 on the following edge.
- Reset collision: reg 3 <= 32'hAA while rst=1 -> reg 3 reads 0 afterwards; a subsequent write of 32'hBB commits; wb_count = 1.
